aes_job_arbiter: RTL and testbench
==================================

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles in RUN waiting for core_data_out_valid.
REQ-002 Parameter GAP_CYCLES, default 2 (legal range 1..15): cycles core_en is held low between jobs.
REQ-003 AES_clk  in  1  single clock; all logic on its rising edge.
REQ-004 AES_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester N has a job pending.
REQ-006 req0_ready / req1_ready  out  1  requester N job accepted this cycle.
REQ-007 req0_data / req1_data  in  128  plaintext block of requester N.
REQ-008 req0_key / req1_key  in  128  cipher key of requester N.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  result consumer accepts.
REQ-011 rsp_id  out  1  requester index of the result.
REQ-012 rsp_data  out  128  ciphertext, or all-zero on error.
REQ-013 rsp_err  out  1  job timed out.
REQ-014 core_en  out  1  drives AES_en of the AES_top core.
REQ-015 core_data_in / core_key_in  out  128  drive AES_data_in / AES_key_in of the core.
REQ-016 core_data_out  in  128  from AES_data_out.
REQ-017 core_data_out_valid  in  1  from AES_data_out_valid.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, RUN, RESP, GAP; the block SHALL serialise all jobs through one core.
REQ-020 IDLE: grant SHALL be round-robin. If only one valid, grant it. If both valid, grant the one not granted last. last_grant resets to 1, so req0 wins the first tie.
REQ-021 reqN_ready SHALL be combinational and high only in IDLE for the granted requester. At most one ready is high per cycle.
REQ-022 On valid&ready, the block SHALL register data, key and grant index. The next cycle is RUN. last_grant SHALL update to the granted index.
REQ-023 RUN: core_en=1. core_data_in and core_key_in SHALL hold the registered values, stable for the whole of RUN.
REQ-024 RUN: a cycle counter SHALL clear on entry and increment each RUN cycle. Its width is $clog2(TIMEOUT_CYCLES+1).
REQ-025 RUN with core_data_out_valid=1: capture core_data_out into rsp_data, set rsp_err=0, go to RESP.
REQ-026 RUN with no valid when the counter equals TIMEOUT_CYCLES-1: set rsp_data=0 and rsp_err=1, go to RESP.
REQ-027 If core_data_out_valid and the timeout occur in the same cycle, valid SHALL win (rsp_err=0).
REQ-028 RESP: core_en=0 and rsp_valid=1. rsp_id, rsp_data and rsp_err SHALL be held stable until rsp_valid&rsp_ready. The block then goes to GAP.
REQ-029 GAP: core_en=0 for exactly GAP_CYCLES cycles, then IDLE. No grant SHALL be made in GAP.
REQ-030 core_data_out_valid outside RUN SHALL be ignored.
REQ-031 core_en SHALL be a registered output, high only in RUN, with no glitches.
REQ-032 Minimum request-to-request period is 1 (IDLE) + RUN length + 1 (RESP, if rsp_ready=1) + GAP_CYCLES cycles.

Reset
REQ-033 Asynchronous assertion SHALL force IDLE and set last_grant=1.
REQ-034 Asynchronous assertion SHALL drive the following outputs to 0: core_en, core_data_in, core_key_in, rsp_valid, rsp_id, rsp_data, rsp_err, busy, counters.
REQ-035 Reset asserted mid-RUN or mid-RESP SHALL abandon the job with no response. After deassertion the first rising edge evaluates IDLE normally.

Verification
REQ-036 Single job: req0 data=00000030_00000000_00000000_00000000, key=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, core model of latency 50 with ciphertext C -> core_en high exactly 50 cycles with stable inputs; rsp_valid, rsp_id=0, rsp_data=C, rsp_err=0.
REQ-037 Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. core_en is low for exactly GAP_CYCLES=2 cycles between jobs.
REQ-038 Timeout: core never asserts valid -> RESP after exactly 64 RUN cycles with rsp_err=1 and rsp_data=0. The next job completes normally.
REQ-039 Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, no req ready, core_en=0. Once rsp_ready=1, GAP follows.
REQ-040 Simultaneous valid and timeout on RUN cycle 63 -> rsp_err=0 and rsp_data=core_data_out.
REQ-041 Reset at RUN cycle 20 -> core_en=0 and rsp_valid=0 immediately (asynchronously). After release, req1 granted alone -> completes normally.

Source files
------------

// File: rtl/aes_job_arbiter_if.sv
// Bundle of requester, response, AES-core and status signals for the AES job arbiter.
// The arbiter takes the slave view; requesters, consumer and core model take the master view.
interface aes_job_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic [127:0] req0_key;

    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic [127:0] req1_key;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_err;

    logic         core_en;
    logic [127:0] core_data_in;
    logic [127:0] core_key_in;
    logic [127:0] core_data_out;
    logic         core_data_out_valid;

    logic         busy;

    modport master (
        output req0_valid, req0_data, req0_key,
        output req1_valid, req1_data, req1_key,
        output rsp_ready,
        output core_data_out, core_data_out_valid,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        input  core_en, core_data_in, core_key_in,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_key,
        input  req1_valid, req1_data, req1_key,
        input  rsp_ready,
        input  core_data_out, core_data_out_valid,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        output core_en, core_data_in, core_key_in,
        output busy
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin front end that serialises AES jobs through a single core,
// with a run timeout, a held response and an idle gap between jobs.
module aes_job_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 2
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    aes_job_arbiter_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic [127:0]  data_q, data_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          core_en_q, core_en_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;

    logic grant_valid;
    logic grant_id;

    // Round-robin pick; only meaningful in IDLE, so ready stays low everywhere else.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;

    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        key_d        = key_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    data_d       = grant_id ? bus.req1_data : bus.req0_data;
                    key_d        = grant_id ? bus.req1_key  : bus.req0_key;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // A result arriving on the last allowed cycle still beats the timeout.
                if (bus.core_data_out_valid) begin
                    rsp_data_d = bus.core_data_out;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    gap_d   = 4'(GAP_CYCLES - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs decoded from the next state so they come straight off flops.
        core_en_d   = (state_d == RUN);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
            key_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
            key_q        <= key_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
        end
    end

    assign bus.core_en      = core_en_q;
    assign bus.core_data_in = data_q;
    assign bus.core_key_in  = key_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: behavioural AES core model, job table,
// response scoreboard, and hand-written contention and mid-run reset sequences.
module tb_aes_job_arbiter;

    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;

    typedef struct {
        logic         v0;
        logic         v1;
        logic [127:0] d0;
        logic [127:0] k0;
        logic [127:0] d1;
        logic [127:0] k1;
        int           lat;     // core latency; 0 = core never answers
        int           stall;   // cycles rsp_ready is held low
        logic         exp_id;
    } job_t;

    typedef struct {
        logic         id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    exp_t sb[$];
    int   core_lat    = 0;
    int   core_cnt;
    logic force_valid = 1'b0;

    aes_job_arbiter_if bus ();

    aes_job_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .GAP_CYCLES     (GAP)
    ) dut (
        .AES_clk   (clk),
        .AES_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: any fixed mixing of data and key is enough to tell jobs apart.
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
        return {d[63:0] ^ k[127:64], d[127:64] ^ k[63:0]} ^ 128'h5a5a_1234_c3c3_8765_0f0f_abcd_f00d_beef;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          core_cnt <= 0;
        else if (bus.core_en) core_cnt <= core_cnt + 1;
        else                 core_cnt <= 0;
    end

    assign bus.core_data_out       = cipher(bus.core_data_in, bus.core_key_in);
    assign bus.core_data_out_valid = (bus.core_en && core_lat > 0 && core_cnt == core_lat - 1) || force_valid;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            check({nm, " scoreboard empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({nm, " rsp_valid"}, bus.rsp_valid, 1'b1);
            check({nm, " rsp_id"},    bus.rsp_id,    e.id);
            check({nm, " rsp_data"},  bus.rsp_data,  e.data);
            check({nm, " rsp_err"},   bus.rsp_err,   e.err);
        end
    endtask

    task automatic run_job(input job_t j, input string nm);
        int           n;
        int           en_cnt;
        int           unstable;
        int           bad_cyc;
        logic         timeout;
        logic [127:0] d;
        logic [127:0] k;
        logic         id0;
        logic         err0;
        logic [127:0] dat0;
        exp_t         e;

        @(negedge clk);
        core_lat       = j.lat;
        bus.req0_valid = j.v0;
        bus.req1_valid = j.v1;
        bus.req0_data  = j.d0;
        bus.req0_key   = j.k0;
        bus.req1_data  = j.d1;
        bus.req1_key   = j.k1;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({nm, " grant"}, {bus.req0_ready, bus.req1_ready}, j.exp_id ? 2'b01 : 2'b10);

        d       = j.exp_id ? j.d1 : j.d0;
        k       = j.exp_id ? j.k1 : j.k0;
        timeout = (j.lat == 0) || (j.lat > TIMEOUT);
        e.id    = j.exp_id;
        e.data  = timeout ? '0 : cipher(d, k);
        e.err   = timeout;
        sb.push_back(e);

        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0; en_cnt = 0; unstable = 0;
        while (!bus.rsp_valid && n < 200) begin
            if (bus.core_en) begin
                en_cnt++;
                if (bus.core_data_in !== d || bus.core_key_in !== k) unstable++;
            end
            @(negedge clk); n++;
        end
        check({nm, " run length"}, en_cnt, timeout ? TIMEOUT : j.lat);
        check({nm, " core inputs stable"}, unstable, 0);
        check({nm, " core_en low in RESP"}, bus.core_en, 1'b0);

        // Backpressure: response held, no grant even with a request pending, stray core valid ignored.
        id0 = bus.rsp_id; dat0 = bus.rsp_data; err0 = bus.rsp_err;
        bad_cyc = 0;
        for (int i = 0; i < j.stall; i++) begin
            bus.req0_valid = 1'b1;
            force_valid    = (i == 2);
            #1;
            if (!bus.rsp_valid || bus.rsp_id !== id0 || bus.rsp_data !== dat0 || bus.rsp_err !== err0 ||
                bus.req0_ready || bus.req1_ready || bus.core_en || !bus.busy)
                bad_cyc++;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        force_valid    = 1'b0;
        if (j.stall > 0) check({nm, " stall hold"}, bad_cyc, 0);

        bus.rsp_ready = 1'b1;
        #1;
        pop_compare(nm);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n = 0; bad_cyc = 0;
        while (bus.busy && n < 40) begin
            if (bus.core_en || bus.rsp_valid) bad_cyc++;
            @(negedge clk); n++;
        end
        check({nm, " gap length"}, n, GAP);
        check({nm, " gap quiet"}, bad_cyc, 0);
    endtask

    initial begin
        job_t jobs[8];
        int   n;
        int   seen;
        logic gid;
        exp_t e;

        jobs[0] = '{1'b1, 1'b0, 128'h00000030_00000000_00000000_00000000,
                    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, '0, '0, 50, 0, 1'b0};
        jobs[1] = '{1'b1, 1'b1, {4{32'h1111_0001}}, {4{32'h2222_0002}},
                    {4{32'h3333_0003}}, {4{32'h4444_0004}}, 10, 0, 1'b1};
        jobs[2] = '{1'b1, 1'b1, {4{32'h5555_0005}}, {4{32'h6666_0006}},
                    {4{32'h7777_0007}}, {4{32'h8888_0008}}, 7, 10, 1'b0};
        jobs[3] = '{1'b0, 1'b1, '0, '0, {4{32'h9999_0009}}, {4{32'haaaa_000a}}, 0, 0, 1'b1};
        jobs[4] = '{1'b0, 1'b1, '0, '0, {4{32'hbbbb_000b}}, {4{32'hcccc_000c}}, 3, 3, 1'b1};
        jobs[5] = '{1'b1, 1'b1, {4{32'hdddd_000d}}, {4{32'heeee_000e}},
                    {4{32'hffff_000f}}, {4{32'h0123_4567}}, 64, 0, 1'b0};
        jobs[6] = '{1'b1, 1'b0, {4{32'h89ab_cdef}}, {4{32'hfedc_ba98}}, '0, '0, 1, 0, 1'b0};
        jobs[7] = '{1'b1, 1'b1, {4{32'h7654_3210}}, {4{32'h0f1e_2d3c}},
                    {4{32'h4b5a_6978}}, {4{32'h8796_a5b4}}, 65, 0, 1'b1};

        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_data  = '0;   bus.req0_key   = '0;
        bus.req1_data  = '0;   bus.req1_key   = '0;
        bus.rsp_ready  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset core_en",   bus.core_en,   1'b0);
        check("reset rsp_valid", bus.rsp_valid, 1'b0);
        check("reset busy",      bus.busy,      1'b0);
        check("reset rsp_data",  bus.rsp_data,  '0);
        check("reset core_in",   {bus.core_data_in ^ bus.core_key_in, bus.rsp_id, bus.rsp_err}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle no ready", {bus.req0_ready, bus.req1_ready, bus.busy}, 3'b000);

        for (int i = 0; i < 8; i++) run_job(jobs[i], $sformatf("job%0d", i));

        // Contention: both requesters always pending, consumer always ready.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        core_lat       = 12;
        bus.rsp_ready  = 1'b1;
        bus.req0_data  = {4{32'hc0de_0000}}; bus.req0_key = {4{32'h0000_aaaa}};
        bus.req1_data  = {4{32'hc0de_1111}}; bus.req1_key = {4{32'h1111_bbbb}};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        gid = bus.req1_ready;
        for (int jb = 0; jb < 4; jb++) begin
            check($sformatf("contend grant%0d", jb), gid, jb[0]);
            e.id   = gid;
            e.data = gid ? cipher(bus.req1_data, bus.req1_key) : cipher(bus.req0_data, bus.req0_key);
            e.err  = 1'b0;
            sb.push_back(e);
            n = 0;
            do begin @(negedge clk); #1; n++; end while (!bus.rsp_valid && n < 200);
            pop_compare($sformatf("contend job%0d", jb));
            if (jb == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            n = 0; seen = 0;
            while (!bus.core_en && n < 40) begin
                if (bus.req0_ready || bus.req1_ready) begin seen++; gid = bus.req1_ready; end
                @(negedge clk); #1; n++;
            end
            // Low window spans RESP, the gap itself, and the IDLE grant cycle.
            if (jb < 3) check($sformatf("contend low%0d", jb), {n, seen}, {GAP + 2, 32'd1});
        end
        bus.rsp_ready = 1'b0;

        // Reset partway through a job: abandoned with no response, then a clean job from req1.
        @(negedge clk);
        core_lat       = 50;
        bus.req0_valid = 1'b1;
        #1;
        check("rst job grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("rst pre core_en", bus.core_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async outputs", {bus.core_en, bus.rsp_valid, bus.busy}, 3'b000);
        check("rst async core_in", bus.core_data_in, '0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid || bus.core_en) n++; end
        check("rst no response", n, 0);
        run_job('{1'b0, 1'b1, '0, '0, {4{32'h5eed_f00d}}, {4{32'hdead_c0de}}, 5, 0, 1'b1}, "after rst");
        check("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
